// File: rtl/up_counter_ctrl.sv
// up_counter_ctrl: run/stop/clear controlled modulo-MAX_COUNT up-counter.
// Each rising edge of the divided tick level advances the count while running.
// Button levels are edge-detected here, and each edge acts on the same clock
// edge at which it is first seen high.
module up_counter_ctrl #(
  parameter int MAX_COUNT   = 10000,
  parameter int COUNT_WIDTH = 14
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_tick,
  input  logic                   i_btn_run_stop,
  input  logic                   i_btn_clear,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_running,
  output logic                   o_carry
);

  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(MAX_COUNT - 1);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic r_tick_d;
  logic r_run_d;
  logic r_clr_d;
  logic tick_pulse;
  logic run_pulse;
  logic clr_pulse;

  // Increment with wrap from LAST back to zero.
  function automatic logic [COUNT_WIDTH-1:0] wrap_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == LAST) begin
      return '0;
    end
    return v + COUNT_WIDTH'(1);
  endfunction

  // Previous-sample registers for edge detection. The buttons reset high so a
  // button held across reset release does not count as a press.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tick_d <= 1'b0;
      r_run_d  <= 1'b1;
      r_clr_d  <= 1'b1;
    end else begin
      r_tick_d <= i_tick;
      r_run_d  <= i_btn_run_stop;
      r_clr_d  <= i_btn_clear;
    end
  end

  assign tick_pulse = i_tick & ~r_tick_d;
  assign run_pulse  = i_btn_run_stop & ~r_run_d;
  assign clr_pulse  = i_btn_clear & ~r_clr_d;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= STOP;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. In STOP a clear beats a simultaneous run press.
  always_comb begin
    state_next = state;
    case (state)
      STOP: begin
        if (clr_pulse) begin
          state_next = CLEAR;
        end else if (run_pulse) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (run_pulse) begin
          state_next = STOP;
        end
      end
      CLEAR: begin
        state_next = STOP;
      end
      default: begin
        state_next = STOP;
      end
    endcase
  end

  // Count and carry. A tick that arrives together with a stop press is still
  // counted because the count uses the current state, not the next one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_count <= '0;
      o_carry <= 1'b0;
    end else begin
      o_carry <= 1'b0;
      if (state == CLEAR) begin
        o_count <= '0;
      end else if (state == RUN && tick_pulse) begin
        o_count <= wrap_inc(o_count);
        o_carry <= (o_count == LAST);
      end
    end
  end

  assign o_running = (state == RUN);

endmodule

// File: doc/up_counter_ctrl.md
# up_counter_ctrl

Run/stop/clear controlled decimal up-counter consuming the slow square wave from the clock divider stage. Detects each rising edge of the divided clock as a one-cycle count enable in the system clock domain. Counts 0..MAX_COUNT-1 with wrap and a carry pulse. Feeds the display/FND driver downstream.

## Interface
- MAX_COUNT, 10000: count modulus; o_count wraps from MAX_COUNT-1 to 0.
- COUNT_WIDTH, 14: width of o_count; must satisfy 2^COUNT_WIDTH >= MAX_COUNT.
- i_clk  in  1  system clock (100 MHz); the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  divided clock level from divider; synchronous to i_clk.
- i_btn_run_stop  in  1  debounced level; each rising edge toggles RUN/STOP.
- i_btn_clear  in  1  debounced level; a rising edge clears the count, honoured only when stopped.
- o_count  out  COUNT_WIDTH  current count value.
- o_running  out  1  high while in RUN.
- o_carry  out  1  one-cycle pulse coinciding with the wrap to 0.

## Operation
- Edge detect: r_tick_d, r_run_d, r_clr_d register the inputs each cycle.
  - tick_pulse = i_tick & ~r_tick_d; run_pulse and clr_pulse are formed the same way.
- FSM states: STOP (reset state), RUN, CLEAR.
  - STOP: clr_pulse -> CLEAR; otherwise run_pulse -> RUN; otherwise stay.
  - RUN: run_pulse -> STOP; clr_pulse ignored.
  - CLEAR: o_count <= 0; unconditionally -> STOP after one cycle. run_pulse and tick_pulse are ignored in this cycle.
- Counting happens only in RUN on tick_pulse.
  - If o_count == MAX_COUNT-1: o_count <= 0 and o_carry <= 1.
  - Else: o_count <= o_count+1.
  - o_carry is 0 in every other cycle.
- In STOP and CLEAR, o_count holds (except the clear to 0). tick_pulse is discarded; a missed tick is never counted later.
- Simultaneous events:
  - STOP with run_pulse and clr_pulse together: clear wins, and FSM ends in STOP.
  - RUN with tick_pulse and run_pulse together: the tick is counted in that same edge, then FSM enters STOP.
  - RUN with tick_pulse at wrap and run_pulse together: wrap and carry occur, then STOP.
- o_running = (state == RUN), registered.
- Arithmetic is unsigned. o_count never reaches MAX_COUNT; there is no out-of-range state.

## Timing
- Reset, synchronous, sampled at the i_clk rising edge with i_reset=1. Values afterwards:
  - state=STOP, o_count=0, o_running=0, o_carry=0.
  - r_tick_d=0, r_run_d=1, r_clr_d=1.
- A button held high across reset release produces no edge; it must fall and rise again.
- Reset asserted mid-count or in CLEAR takes effect at that edge and overrides all pulses.
- Input to action latency:
  - An input first sampled high at edge k (previous sample low) causes its action at edge k. Outputs reflect it after edge k.
  - There is no additional pipeline.
- FSM timing:
  - run_pulse at edge k: o_running changes after edge k.
  - clr_pulse at edge k (STOP): CLEAR occupies cycle k..k+1, with o_count=0 after edge k+1. The FSM is back in STOP after edge k+1.
- One count per i_tick rising edge regardless of i_tick high time (divider high time is 500,000 cycles).
- o_carry is high for exactly one i_clk cycle per wrap.

## Test plan
- Reset: hold i_reset 3 cycles with i_btn_run_stop=1. Release, then toggle i_tick for 5 periods. Required: o_running=0, o_count=0, o_carry=0 throughout.
- Count and wrap (MAX_COUNT=5, i_tick period 20 cycles): press run, apply 7 tick rising edges.
  - o_count sequence: 1,2,3,4,0,1,2.
  - o_carry high exactly one cycle, at the 5th edge.
- Stop/hold: in RUN at count 3, press run_stop, apply 4 ticks. Required: o_count stays 3 and o_running=0. Press run again, apply 1 tick: o_count=4.
- Clear gating:
  - In RUN at count 2, press clear: count keeps running with no change.
  - Stop, then press clear: o_count=0 two edges after the press edge, and the FSM is in STOP.
- Simultaneous events:
  - In STOP, run and clear rise together: o_count=0 and o_running stays 0.
  - In RUN, tick and run rise on the same edge: count increments once, then o_running=0.
- Reset mid-operation: assert i_reset at count 4 coincident with a tick edge. Required: o_count=0, o_carry=0, o_running=0 after that edge.
